// File: rtl/finn_latency_pkg.sv
// Shared types and defaults for the FINN accelerator latency monitor.
// Nothing here holds state, so it adds no latency and no backpressure.
package finn_latency_pkg;

    localparam int DEF_TS_WIDTH         = 32;
    localparam int DEF_DEPTH            = 16;
    localparam int DEF_BEATS_PER_SAMPLE = 10;

    // Reset value of the running minimum; the first published latency always replaces it.
    localparam logic [DEF_TS_WIDTH-1:0] MIN_INIT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } mon_state_e;

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through timestamp store. The head is valid in the same cycle as !empty.
// A push to a full store is dropped unless a pop happens in the same cycle; flush empties it in one cycle.
module ts_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/finn_latency_monitor.sv
// Passive tap measuring FINN inference latency (first input beat of a sample to its output beat).
// Results are registered one cycle after the output beat; the tapped streams are never backpressured.
module finn_latency_monitor
    import finn_latency_pkg::*;
#(
    parameter int TS_WIDTH         = DEF_TS_WIDTH,
    parameter int DEPTH            = DEF_DEPTH,
    parameter int BEATS_PER_SAMPLE = DEF_BEATS_PER_SAMPLE
) (
    input  logic                sys_clk,
    input  logic                resetn_async,
    input  logic                enable,
    input  logic                clear,
    input  logic                in_tvalid,
    input  logic                in_tready,
    input  logic                out_tvalid,
    input  logic                out_tready,
    input  logic [7:0]          out_tdata,
    output logic                lat_valid,
    output logic [TS_WIDTH-1:0] lat_cycles,
    output logic [7:0]          result_data,
    output logic [TS_WIDTH-1:0] lat_min,
    output logic [TS_WIDTH-1:0] lat_max,
    output logic [15:0]         sample_count,
    output logic                overflow,
    output logic                orphan,
    output logic                busy
);
    localparam int BW = (BEATS_PER_SAMPLE > 1) ? $clog2(BEATS_PER_SAMPLE) : 1;
    localparam logic [BW-1:0]       BCNT_LAST   = BW'(BEATS_PER_SAMPLE - 1);
    localparam logic [TS_WIDTH-1:0] LAT_MIN_RST = {TS_WIDTH{MIN_INIT[0]}};

    logic [2:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    mon_state_e          state_q, state_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                lat_valid_q, lat_valid_d;
    logic [TS_WIDTH-1:0] lat_cycles_q, lat_cycles_d;
    logic [7:0]          result_data_q, result_data_d;
    logic [TS_WIDTH-1:0] lat_min_q, lat_min_d;
    logic [TS_WIDTH-1:0] lat_max_q, lat_max_d;
    logic [15:0]         sample_count_q, sample_count_d;
    logic                overflow_q, overflow_d;
    logic                orphan_q, orphan_d;
    logic                busy_q, busy_d;

    logic                in_beat, out_beat, push_ev, pop_ev, bypass, publish;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TS_WIDTH-1:0] fifo_head, lat_new;

    // Reset asserts immediately but releases only after three sys_clk edges.
    assign rst_sync_d = {rst_sync_q[1:0], 1'b1};
    assign rst_n      = rst_sync_q[2];

    always_ff @(posedge sys_clk or negedge resetn_async) begin
        if (!resetn_async) rst_sync_q <= '0;
        else               rst_sync_q <= rst_sync_d;
    end

    ts_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_ts_fifo (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .flush    (clear),
        .push     (fifo_push),
        .push_dat (ts_q),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        in_beat  = in_tvalid & in_tready;
        out_beat = out_tvalid & out_tready;
        push_ev  = (state_q == ST_RUN) & in_beat & (bcnt_q == '0);
        pop_ev   = (state_q != ST_IDLE) & out_beat;
        // A pop racing the push into an empty store measures that same timestamp.
        bypass   = push_ev & pop_ev & fifo_empty;
        publish  = pop_ev & (~fifo_empty | push_ev);
        lat_new  = bypass ? '0 : ts_q - fifo_head;

        ts_d           = ts_q + 1'b1;
        state_d        = state_q;
        bcnt_d         = bcnt_q;
        lat_valid_d    = 1'b0;
        lat_cycles_d   = lat_cycles_q;
        result_data_d  = result_data_q;
        lat_min_d      = lat_min_q;
        lat_max_d      = lat_max_q;
        sample_count_d = sample_count_q;
        overflow_d     = overflow_q;
        orphan_d       = orphan_q;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;

        if (clear) begin
            state_d        = ST_IDLE;
            bcnt_d         = '0;
            lat_min_d      = LAT_MIN_RST;
            lat_max_d      = '0;
            sample_count_d = '0;
            overflow_d     = 1'b0;
            orphan_d       = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (enable) state_d = ST_RUN;
                ST_RUN:   if (!enable) state_d = ST_FLUSH;
                ST_FLUSH: begin
                    if (enable)          state_d = ST_RUN;
                    else if (fifo_empty) state_d = ST_IDLE;
                end
                default:  state_d = ST_IDLE;
            endcase

            if ((state_q == ST_RUN) && in_beat)
                bcnt_d = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + 1'b1;

            fifo_push = push_ev & ~bypass;
            fifo_pop  = pop_ev & ~fifo_empty;
            if (push_ev && fifo_full && !pop_ev)  overflow_d = 1'b1;
            if (pop_ev && fifo_empty && !push_ev) orphan_d   = 1'b1;

            if (publish) begin
                lat_valid_d    = 1'b1;
                lat_cycles_d   = lat_new;
                result_data_d  = out_tdata;
                lat_min_d      = (lat_new < lat_min_q) ? lat_new : lat_min_q;
                lat_max_d      = (lat_new > lat_max_q) ? lat_new : lat_max_q;
                sample_count_d = (sample_count_q == 16'hFFFF) ? sample_count_q
                                                              : sample_count_q + 16'd1;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ts_q           <= '0;
            bcnt_q         <= '0;
            lat_valid_q    <= 1'b0;
            lat_cycles_q   <= '0;
            result_data_q  <= '0;
            lat_min_q      <= LAT_MIN_RST;
            lat_max_q      <= '0;
            sample_count_q <= '0;
            overflow_q     <= 1'b0;
            orphan_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ts_q           <= ts_d;
            bcnt_q         <= bcnt_d;
            lat_valid_q    <= lat_valid_d;
            lat_cycles_q   <= lat_cycles_d;
            result_data_q  <= result_data_d;
            lat_min_q      <= lat_min_d;
            lat_max_q      <= lat_max_d;
            sample_count_q <= sample_count_d;
            overflow_q     <= overflow_d;
            orphan_q       <= orphan_d;
            busy_q         <= busy_d;
        end
    end

    assign lat_valid    = lat_valid_q;
    assign lat_cycles   = lat_cycles_q;
    assign result_data  = result_data_q;
    assign lat_min      = lat_min_q;
    assign lat_max      = lat_max_q;
    assign sample_count = sample_count_q;
    assign overflow     = overflow_q;
    assign orphan       = orphan_q;
    assign busy         = busy_q;

endmodule

// File: doc/finn_latency_monitor.md
FINN_LATENCY_MONITOR -- requirements
Module: finn_latency_monitor

Interface
REQ-001 SHALL have parameter TS_WIDTH, default 32: timestamp and latency width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, power of two: number of outstanding timestamps held.
REQ-003 SHALL have parameter BEATS_PER_SAMPLE, default 10: input beats that make up one inference.
REQ-004 SHALL have port sys_clk  input  1  clock; all logic is on the rising edge.
REQ-005 SHALL have port resetn_async  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  arms measurement; level-sensitive.
REQ-007 SHALL have port clear  input  1  synchronous single-cycle clear of statistics, FIFO and stickies.
REQ-008 SHALL have ports in_tvalid, in_tready  input  1 each  tapped FINN input handshake; observe only.
REQ-009 SHALL have ports out_tvalid, out_tready  input  1 each  tapped FINN output handshake; observe only.
REQ-010 SHALL have port out_tdata  input  8  tapped FINN result byte.
REQ-011 SHALL have port lat_valid  output  1  one-cycle pulse when a new latency is published.
REQ-012 SHALL have port lat_cycles  output  TS_WIDTH  most recent latency.
REQ-013 SHALL have port result_data  output  8  out_tdata captured with the published latency.
REQ-014 SHALL have ports lat_min, lat_max  output  TS_WIDTH each  running extremes.
REQ-015 SHALL have port sample_count  output  16  published latencies; saturates at 0xFFFF.
REQ-016 SHALL have ports overflow, orphan, busy  output  1 each  sticky FIFO-full drop, sticky pop-on-empty, state not IDLE.

Function
REQ-017 SHALL run a free-running counter ts that increments every cycle and wraps modulo 2^TS_WIDTH.
REQ-018 SHALL have input beat = in_tvalid & in_tready, and output beat = out_tvalid & out_tready.
REQ-019 SHALL count input beats 0..BEATS_PER_SAMPLE-1 in RUN only; the counter wraps to 0 after the last beat.
REQ-020 SHALL push ts into the FIFO when an input beat occurs in RUN with the beat counter at 0.
REQ-021 SHALL pop the FIFO head on every output beat in RUN or FLUSH.
REQ-022 SHALL compute latency = ts - head modulo 2^TS_WIDTH, with no sign or wrap handling beyond that.
REQ-023 SHALL register lat_cycles and result_data, and pulse lat_valid, exactly one cycle after the output beat.
REQ-024 SHALL publish latency 0 when a push and a pop coincide with the FIFO empty; the FIFO stays empty and orphan is not set.
REQ-025 SHALL drop the push and set overflow on a push to a full FIFO with no coincident pop; push and pop with the FIFO full SHALL both proceed.
REQ-026 SHALL set orphan on a pop from an empty FIFO with no coincident push, with no lat_valid and no statistics change.
REQ-027 SHALL update lat_min and lat_max in the same cycle as lat_valid, and increment sample_count, saturating.
REQ-028 SHALL have states IDLE, RUN and FLUSH.
REQ-029 SHALL move IDLE->RUN when enable=1, RUN->FLUSH when enable=0, FLUSH->IDLE when the FIFO is empty, and FLUSH->RUN when enable=1.
REQ-030 SHALL ignore input and output beats in IDLE.
REQ-031 SHALL have clear take priority over all events in its cycle: FIFO emptied, beat counter to 0, lat_min all-ones, lat_max 0, sample_count 0, stickies 0, state IDLE; ts is unaffected.

Reset
REQ-032 SHALL, while resetn_async=0, hold ts=0, FIFO empty, beat counter 0, state IDLE, lat_valid=0, lat_cycles=0, result_data=0, lat_min all-ones, lat_max=0, sample_count=0, overflow=0, orphan=0, busy=0.
REQ-033 SHALL deassert reset synchronously to sys_clk through a 3-stage synchroniser inside the block; an in-flight measurement at reset SHALL be discarded.

Structure
REQ-034 SHALL place the state enum, default TS_WIDTH/DEPTH/BEATS_PER_SAMPLE and the MIN_INIT constant in package finn_latency_pkg.
REQ-035 SHALL implement the timestamp store as one sub-module, ts_fifo: synchronous FWFT, DEPTH x TS_WIDTH, with full/empty and a flush input.

Verification
REQ-036 SHALL cover: enable=1, 10 input beats from ts=20 then 1 output beat at ts=57 -> lat_valid at ts=58, lat_cycles=37, sample_count=1.
REQ-037 SHALL cover: 17 samples pushed with DEPTH=16 and no output -> overflow=1 on the 17th, then 16 pops give 16 latencies in order.
REQ-038 SHALL cover: output beat with the FIFO empty -> orphan=1, lat_valid=0; coincident push and pop on empty -> lat_cycles=0.
REQ-039 SHALL cover: head=0xFFFFFFF0 and pop at ts=0x00000010 -> lat_cycles=0x20.
REQ-040 SHALL cover: enable dropped with 3 pending -> FLUSH, 3 pops, then IDLE and busy=0; clear mid-RUN -> all statistics at reset values.
REQ-041 SHALL cover: resetn_async asserted with pending entries -> on release, FIFO empty and no lat_valid from stale entries.
